// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: master-side per-slot LT_ADDR/packet-type scheduler with per-link ARQ tracking.
// Optional feature macro TX_SCHED_TPOLL_EN adds per-link poll-interval counters that preempt round-robin.
module tx_link_scheduler #(
    parameter int NLINK   = 7,
    parameter int TPOLL_W = 8
) (
    input  logic               clk_6M,
    input  logic               rstz,
    input  logic               p_1us,
    input  logic               m_tslot_p,
    input  logic               sched_en,
    input  logic [7:0]         link_active,
    input  logic [7:0]         txq_pending,
    input  logic [3:0]         regi_data_pktype,
    input  logic [TPOLL_W-1:0] regi_tpoll,
    input  logic [7:0]         dec_flow,
    input  logic [7:0]         dec_arqn,
    input  logic               ckheader_endp,
    input  logic               dec_hecgood,
    input  logic [2:0]         dec_lt_addr,
    output logic               sched_valid,
    output logic [2:0]         sched_lt_addr,
    output logic [3:0]         sched_pktype,
    output logic               sched_retx,
    output logic [7:0]         txq_pop,
    output logic               rsp_timeout_p
);
    typedef enum logic [1:0] {IDLE, ARB, GRANT, WAIT_RSP} state_t;
    state_t     state;
    logic [2:0] rr_ptr;
    logic [7:0] outst, act, elig, ack_clr, set_mask;
    logic       is_data, match;
    logic       data_hit, poll_hit, pre_hit, g_hit, g_data;
    logic [2:0] data_n, poll_n, pre_n, g_n, cand;

    function automatic logic [2:0] rr_wrap(input logic [2:0] p, input int i);
        logic [3:0] s;
        s = {1'b0, p} + 4'(i);
        return (s > 4'(NLINK)) ? 3'(s - 4'(NLINK)) : s[2:0];
    endfunction

    assign act   = link_active & 8'hFE;
    assign elig  = act & dec_flow & (txq_pending | outst);
    // A response only counts while its link is still up; otherwise the grant ages into a timeout.
    assign match = sched_en && state == WAIT_RSP && ckheader_endp && dec_hecgood &&
                   dec_lt_addr == sched_lt_addr && link_active[sched_lt_addr];
    assign ack_clr  = (match && is_data && dec_arqn[sched_lt_addr]) ? 8'b1 << sched_lt_addr : 8'b0;
    assign set_mask = (sched_en && state == ARB && g_hit && g_data) ? 8'b1 << g_n : 8'b0;

    always_comb begin
        data_hit = 1'b0;
        data_n   = '0;
        poll_hit = 1'b0;
        poll_n   = '0;
        cand     = '0;
        for (int i = NLINK - 1; i >= 0; i--) begin
            cand = rr_wrap(rr_ptr, i);
            if (elig[cand]) begin
                data_hit = 1'b1;
                data_n   = cand;
            end
            if (act[cand]) begin
                poll_hit = 1'b1;
                poll_n   = cand;
            end
        end
        g_hit  = pre_hit | data_hit | poll_hit;
        g_n    = pre_hit ? pre_n : data_hit ? data_n : poll_n;
        g_data = pre_hit ? elig[pre_n] : data_hit;
    end

`ifdef TX_SCHED_TPOLL_EN
    logic [TPOLL_W-1:0] cnt [1:NLINK];

    always_ff @(posedge clk_6M) begin
        for (int n = 1; n <= NLINK; n++) begin
            if (!rstz || !link_active[n])
                cnt[n] <= '0;
            else if (match && sched_lt_addr == 3'(n))
                cnt[n] <= TPOLL_W'(m_tslot_p);
            else if (m_tslot_p && ~&cnt[n])
                cnt[n] <= cnt[n] + 1'b1;
        end
    end

    always_comb begin
        pre_hit = 1'b0;
        pre_n   = '0;
        for (int n = NLINK; n >= 1; n--) begin
            if (act[n] && regi_tpoll != '0 && cnt[n] >= regi_tpoll) begin
                pre_hit = 1'b1;
                pre_n   = 3'(n);
            end
        end
    end
`else
    logic tpoll_unused;
    assign tpoll_unused = ^regi_tpoll;
    assign pre_hit      = 1'b0;
    assign pre_n        = '0;
`endif

    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            state         <= IDLE;
            sched_valid   <= 1'b0;
            sched_lt_addr <= '0;
            sched_pktype  <= '0;
            sched_retx    <= 1'b0;
            txq_pop       <= '0;
            rsp_timeout_p <= 1'b0;
            rr_ptr        <= 3'd1;
            outst         <= '0;
            is_data       <= 1'b0;
        end else begin
            txq_pop       <= ack_clr;
            rsp_timeout_p <= 1'b0;
            outst         <= ((outst & ~ack_clr) | set_mask) & act;
            if (!sched_en) begin
                state       <= IDLE;
                sched_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (m_tslot_p) state <= ARB;
                    ARB: begin
                        state       <= g_hit ? GRANT : IDLE;
                        sched_valid <= g_hit;
                        if (g_hit) begin
                            sched_lt_addr <= g_n;
                            sched_pktype  <= g_data ? regi_data_pktype : 4'b0001;
                            sched_retx    <= g_data && outst[g_n];
                            is_data       <= g_data;
                            if (!pre_hit) rr_ptr <= (g_n == 3'(NLINK)) ? 3'd1 : g_n + 3'd1;
                        end
                    end
                    GRANT: if (p_1us) state <= WAIT_RSP;
                    WAIT_RSP: begin
                        // A response arriving with the next slot pulse is consumed before re-arbitrating.
                        if (m_tslot_p || match) begin
                            state         <= m_tslot_p ? ARB : IDLE;
                            sched_valid   <= 1'b0;
                            rsp_timeout_p <= m_tslot_p && !match;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
